// File: rtl/mul_256b_sched.sv
// Schedules 16 word-pair products of a 256x256 unsigned multiply onto one external
// 64x64 multiplier and shift-accumulates the returns into a 512-bit result.
module mul_256b_sched #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [511:0] r_o,
  output logic         mul_vld_o,
  output logic [63:0]  mul_a_o,
  output logic [63:0]  mul_b_o,
  input  logic [127:0] mul_r_i,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Travels alongside each product through the multiplier latency.
  typedef struct packed {
    logic       vld;
    logic       last;
    logic [2:0] sh;
  } tag_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_k;
  logic [255:0] r_a;
  logic [255:0] r_b;
  logic [511:0] r_acc;
  tag_t         r_pipe [MUL_LAT];

  tag_t         w_tag_in;
  tag_t         w_tag_out;
  logic         w_accept;
  logic         w_retire;
  logic         w_last_retire;
  logic [511:0] w_addend;
  logic [511:0] w_acc_sum;

  assign w_accept      = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_tag_out     = r_pipe[MUL_LAT-1];
  assign w_retire      = w_tag_out.vld;
  assign w_last_retire = w_tag_out.vld && w_tag_out.last;
  assign w_addend      = {384'b0, mul_r_i} << {w_tag_out.sh, 6'b0};
  assign w_acc_sum     = r_acc + w_addend;

  assign busy_o      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done_o      = (r_state == S_DONE);
  assign dbg_state_o = r_state;

  always_comb begin
    w_state_nxt = r_state;
    mul_vld_o   = 1'b0;
    mul_a_o     = '0;
    mul_b_o     = '0;
    w_tag_in    = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mul_vld_o     = 1'b1;
        mul_a_o       = r_a[{r_k[1:0], 6'b0} +: 64];
        mul_b_o       = r_b[{r_k[3:2], 6'b0} +: 64];
        w_tag_in.vld  = 1'b1;
        w_tag_in.last = (r_k == 4'd15);
        w_tag_in.sh   = {1'b0, r_k[1:0]} + {1'b0, r_k[3:2]};
        if (r_k == 4'd15) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_retire) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = start_i ? S_ISSUE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_o   <= '0;
      for (int n = 0; n < MUL_LAT; n++) r_pipe[n] <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= a_i;
        r_b   <= b_i;
        r_acc <= '0;
        r_k   <= '0;
      end else begin
        if (r_state == S_ISSUE) r_k <= r_k + 4'd1;
        if (w_retire) r_acc <= w_acc_sum;
      end
      // The result register changes only when the final partial lands.
      if (w_last_retire) r_o <= w_acc_sum;
      r_pipe[0] <= w_tag_in;
      for (int n = 1; n < MUL_LAT; n++) r_pipe[n] <= r_pipe[n-1];
    end
  end

endmodule

// File: tb/tb_mul_256b_sched.sv
// Bench for mul_256b_sched: two instances (multiplier latency 1 and 3) driven by the
// same stimulus, each checked every cycle against a cycle-count model of the schedule.
module tb_mul_256b_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic [255:0] a;
  logic [255:0] b;

  logic [1:0]             busy;
  logic [1:0]             done;
  logic [1:0]             mvld;
  logic [1:0][511:0]      r;
  logic [1:0][63:0]       ma_o;
  logic [1:0][63:0]       mb_o;
  logic [1:0][127:0]      mr_i;
  logic [1:0][1:0]        st;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mul_256b_sched #(.MUL_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy[0]), .done_o(done[0]), .r_o(r[0]),
    .mul_vld_o(mvld[0]), .mul_a_o(ma_o[0]), .mul_b_o(mb_o[0]),
    .mul_r_i(mr_i[0]), .dbg_state_o(st[0])
  );

  mul_256b_sched #(.MUL_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy[1]), .done_o(done[1]), .r_o(r[1]),
    .mul_vld_o(mvld[1]), .mul_a_o(ma_o[1]), .mul_b_o(mb_o[1]),
    .mul_r_i(mr_i[1]), .dbg_state_o(st[1])
  );

  // External multipliers: not reset, and return noise on idle slots.
  logic [127:0]      mp0;
  logic [2:0][127:0] mp1;
  always @(posedge clk) begin
    mp0    <= mvld[0] ? ({64'b0, ma_o[0]} * {64'b0, mb_o[0]}) : {$urandom, $urandom, $urandom, $urandom};
    mp1[0] <= mvld[1] ? ({64'b0, ma_o[1]} * {64'b0, mb_o[1]}) : {$urandom, $urandom, $urandom, $urandom};
    mp1[1] <= mp1[0];
    mp1[2] <= mp1[1];
  end
  assign mr_i[0] = mp0;
  assign mr_i[1] = mp1[2];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: t counts cycles since the accept edge (0 = nothing in progress).
  int               t      [2];
  logic [1:0][255:0] m_a;
  logic [1:0][255:0] m_b;
  logic [1:0][511:0] m_prod;
  logic [1:0][511:0] m_r;
  int               done_cnt [2];
  int               done_cyc [2];
  int               vld_cnt  [2];
  int               bad_word [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      t[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0; vld_cnt[d] = 0; bad_word[d] = 0;
    end
    m_a = '0; m_b = '0; m_prod = '0; m_r = '0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int           lat;
      int           k;
      logic         e_busy, e_vld, e_done;
      logic [255:0] aa, bb;
      logic [63:0]  e_a, e_b;
      lat = (d == 0) ? 1 : 3;
      if (!rst_n) begin
        t[d] = 0;
        m_r[d] = '0;
      end
      e_busy = (t[d] >= 1) && (t[d] <= 16 + lat);
      e_vld  = (t[d] >= 1) && (t[d] <= 16);
      e_done = (t[d] == 17 + lat);
      k  = t[d] - 1;
      aa = m_a[d];
      bb = m_b[d];
      e_a = e_vld ? aa[64*(k%4) +: 64] : 64'd0;
      e_b = e_vld ? bb[64*(k/4) +: 64] : 64'd0;
      chk($sformatf("dut%0d busy c%0d", d, cyc), 512'(busy[d]), 512'(e_busy));
      chk($sformatf("dut%0d done c%0d", d, cyc), 512'(done[d]), 512'(e_done));
      chk($sformatf("dut%0d mul_vld c%0d", d, cyc), 512'(mvld[d]), 512'(e_vld));
      chk($sformatf("dut%0d mul_a c%0d", d, cyc), 512'(ma_o[d]), 512'(e_a));
      chk($sformatf("dut%0d mul_b c%0d", d, cyc), 512'(mb_o[d]), 512'(e_b));
      chk($sformatf("dut%0d r c%0d", d, cyc), r[d], m_r[d]);
      chk($sformatf("dut%0d active_state c%0d", d, cyc), 512'(st[d] != 2'd0), 512'(e_busy || e_done));
      if (done[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (mvld[d]) begin
        vld_cnt[d]++;
        if (ma_o[d] != 64'hFFFF_FFFF_FFFF_FFFF || mb_o[d] != 64'hFFFF_FFFF_FFFF_FFFF) bad_word[d]++;
      end
      if (rst_n) begin
        if (start && !e_busy) begin
          m_a[d]    = a;
          m_b[d]    = b;
          m_prod[d] = {256'b0, a} * {256'b0, b};
          t[d]      = 1;
        end else if (t[d] != 0) begin
          t[d] = (t[d] == 17 + lat) ? 0 : t[d] + 1;
        end
        if (t[d] == 17 + lat) m_r[d] = m_prod[d];
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) begin
      case ($urandom_range(0, 5))
        0:       v[32*w +: 32] = 32'h0;
        1:       v[32*w +: 32] = 32'hFFFF_FFFF;
        default: v[32*w +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  int st_cyc;

  task automatic op(input logic [255:0] av, input logic [255:0] bv);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv; st_cyc = cyc;
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; vld_cnt[d] = 0; bad_word[d] = 0;
    end
    @(posedge clk); #1;
    start = 1'b0; a = rnd256(); b = rnd256();
  endtask

  task automatic wait_done_all(input int budget);
    int n = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses_dut0", 512'(done_cnt[0]), 512'd1);
    chk("done_pulses_dut1", 512'(done_cnt[1]), 512'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] lit;
    logic [255:0] x1, y1, x2, y2;
    int dc1, n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: 1*1, pins issue window and completion latency.
    op(256'd1, 256'd1);
    wait_done_all(40);
    chk("t1_r_dut0", r[0], 512'd1);
    chk("t1_r_dut1", r[1], 512'd1);
    chk("t1_done_cycle_dut0", 512'(done_cyc[0] - st_cyc), 512'd18);
    chk("t1_done_cycle_dut1", 512'(done_cyc[1] - st_cyc), 512'd20);
    chk("t1_vld_cycles_dut0", 512'(vld_cnt[0]), 512'd16);
    chk("t1_vld_cycles_dut1", 512'(vld_cnt[1]), 512'd16);

    // T2: all-ones operands.
    op('1, '1);
    wait_done_all(40);
    lit = 512'd0 - (512'd1 << 257) + 512'd1;
    chk("t2_r_dut0", r[0], lit);
    chk("t2_r_dut1", r[1], lit);
    chk("t2_words_dut0", 512'(bad_word[0]), 512'd0);
    chk("t2_words_dut1", 512'(bad_word[1]), 512'd0);

    // T3: only the top word pair is nonzero; then a zero operand.
    op(256'd1 << 192, 256'd1 << 192);
    wait_done_all(40);
    chk("t3_r_dut0", r[0], 512'd1 << 384);
    chk("t3_r_dut1", r[1], 512'd1 << 384);
    op(256'd0, rnd256());
    wait_done_all(40);
    chk("t3_zero_dut0", r[0], 512'd0);
    chk("t3_zero_dut1", r[1], 512'd0);

    // T4: starts while busy are ignored.
    x1 = rnd256(); y1 = rnd256();
    op(x1, y1);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; a = rnd256(); b = rnd256();
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1; a = rnd256(); b = rnd256();
    @(posedge clk); #1 start = 1'b0;
    wait_done_all(40);
    chk("t4_r_dut0", r[0], {256'b0, x1} * {256'b0, y1});
    chk("t4_r_dut1", r[1], {256'b0, x1} * {256'b0, y1});

    // T5: restart in the done cycle of the latency-1 instance.
    x1 = rnd256(); y1 = rnd256(); x2 = rnd256(); y2 = rnd256();
    op(x1, y1);
    n = 0;
    while (!done[0] && n < 40) begin @(posedge clk); #1; n++; end
    dc1 = cyc;
    chk("t5_first_r", r[0], {256'b0, x1} * {256'b0, y1});
    start = 1'b1; a = x2; b = y2;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!done[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("t5_spacing", 512'(cyc - dc1), 512'd18);
    chk("t5_second_r", r[0], {256'b0, x2} * {256'b0, y2});
    repeat (30) @(posedge clk);

    // T6: reset mid-operation, then 3*5.
    op(rnd256(), rnd256());
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op(256'd3, 256'd5);
    wait_done_all(40);
    chk("t6_r_dut0", r[0], 512'd15);
    chk("t6_r_dut1", r[1], 512'd15);

    // Random traffic, including starts during busy and back-to-back starts.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a = rnd256(); b = rnd256();
      rst_n = ($urandom_range(0, 499) != 0);
    end
    #0 start = 1'b0; rst_n = 1'b1;
    repeat (30) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
